// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multiplexed seven-segment debug display driver.
// Picks one of NSRC hex words and snapshots it once per frame so the display
// never tears. Scans DIGITS common-anode digits, with a blank slot at the
// start of every digit.
// Optional feature: define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_mux #(
    parameter  int DIGITS    = 4,
    parameter  int NSRC      = 4,
    parameter  int SCAN_DIV  = 16384,
    parameter  int BLANK_CYC = 2,
    localparam int SEL_W     = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NSRC*DIGITS*4-1:0]   src_data,
    input  logic [SEL_W-1:0]           src_sel,
    input  logic [DIGITS-1:0]          dp_in,
    input  logic                       hold,
    output logic [DIGITS-1:0]          anode,
    output logic [7:0]                 segment,
    output logic                       frame_start
);

    localparam int W     = DIGITS * 4;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PRE_W-1:0]  pre;
    logic [IDX_W-1:0]  idx;
    logic [W-1:0]      snap;
    logic [DIGITS-1:0] dpsnap;
    logic [W-1:0]      sel_word;
    logic [3:0]        nib;
    logic              glyph_off;
    logic              pre_last;
    logic              idx_last;
    logic              boundary;
    logic              lit;

    // Hex glyph in {g,f,e,d,c,b,a} order, active low.
    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    // Source mux; any index without a matching source falls back to source 0.
    always_comb begin
        sel_word = src_data[W-1:0];
        for (int k = 0; k < NSRC; k++) begin
            if (src_sel == SEL_W'(k)) sel_word = src_data[k*W +: W];
        end
    end

    assign pre_last = (pre == PRE_W'(SCAN_DIV - 1));
    assign idx_last = (idx == IDX_W'(DIGITS - 1));
    assign boundary = (pre == '0) && (idx == '0);
    assign lit      = (pre >= PRE_W'(BLANK_CYC));
    assign nib      = snap[idx*4 +: 4];

`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0] zero_from;

    // zero_from[i]: nibble i and every higher nibble of the snapshot are zero.
    always_comb begin
        logic run;
        run = 1'b1;
        zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run = run & (snap[i*4 +: 4] == 4'h0);
            zero_from[i] = run;
        end
    end

    assign glyph_off = (idx != '0) && zero_from[idx];
`else
    assign glyph_off = 1'b0;
`endif

    // Prescaler, digit index and frame snapshot.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pre    <= '0;
            idx    <= '0;
            snap   <= '0;
            dpsnap <= '0;
        end else begin
            pre <= pre_last ? '0 : pre + PRE_W'(1);
            if (pre_last) idx <= idx_last ? '0 : idx + IDX_W'(1);
            if (boundary && !hold) begin
                snap   <= sel_word;
                dpsnap <= dp_in;
            end
        end
    end

    // Aligned output registers, one cycle behind pre/idx.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            anode       <= '1;
            segment     <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            if (lit) begin
                anode   <= ~(DIGITS'(1) << idx);
                segment <= {~dpsnap[idx], glyph_off ? 7'h7F : font(nib)};
            end else begin
                anode   <= '1;
                segment <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
module tb_seg7_scan_mux;

    localparam int DIGITS    = 4;
    localparam int NSRC      = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;

    logic                     clock = 1'b0;
    logic                     resetn;
    logic [NSRC*DIGITS*4-1:0] src_data;
    logic [1:0]               src_sel;
    logic [DIGITS-1:0]        dp_in;
    logic                     hold;
    logic [DIGITS-1:0]        anode;
    logic [7:0]               segment;
    logic                     frame_start;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] s;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seg7_scan_mux #(
        .DIGITS(DIGITS), .NSRC(NSRC), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clock(clock), .resetn(resetn), .src_data(src_data), .src_sel(src_sel),
        .dp_in(dp_in), .hold(hold), .anode(anode), .segment(segment),
        .frame_start(frame_start)
    );

    always #5 clock = ~clock;

    // Skip any current lit window, then measure the next one (all at negedges).
    task automatic capture(output logic [3:0] a, output logic [7:0] s,
                           output int len, output int gap, output bit to);
        int n;
        n = 0;
        while (anode != 4'hF && n < 200) begin @(negedge clock); n++; end
        gap = 0;
        while (anode == 4'hF && n < 200) begin @(negedge clock); n++; gap++; end
        a = anode;
        s = segment;
        len = 0;
        while (anode == a && segment == s && n < 200) begin @(negedge clock); n++; len++; end
        to = (n >= 200);
    endtask

    task automatic wait_frame(output bit to);
        int n;
        n = 0;
        while (!frame_start && n < 100) begin @(negedge clock); n++; end
        to = !frame_start;
    endtask

    task automatic wait_anode(input logic [3:0] a, output bit to);
        int n;
        n = 0;
        while (anode != a && n < 100) begin @(negedge clock); n++; end
        to = (anode != a);
    endtask

    function automatic logic [NSRC*DIGITS*4-1:0] set_src(
        input logic [NSRC*DIGITS*4-1:0] d, input int k, input logic [15:0] w);
        logic [NSRC*DIGITS*4-1:0] r;
        r = d;
        r[k*16 +: 16] = w;
        return r;
    endfunction

    task automatic push4(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
        sb.push_back('{a: 4'b1110, s: s0});
        sb.push_back('{a: 4'b1101, s: s1});
        sb.push_back('{a: 4'b1011, s: s2});
        sb.push_back('{a: 4'b0111, s: s3});
    endtask

    task automatic test_reset;
        int pos[$];
        resetn   = 1'b0;
        src_data = set_src('0, 0, 16'h1234);
        src_sel  = 2'd0;
        dp_in    = '0;
        hold     = 1'b0;
        repeat (5) @(negedge clock);
        n_checks++;
        if ({anode, segment, frame_start} !== {4'hF, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got anode=%b seg=%h fs=%b, want 1111 ff 0",
                     anode, segment, frame_start);
        end
        resetn = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clock);
            if (frame_start) pos.push_back(i);
        end
        n_checks++;
        if (pos.size() != 3) begin
            n_fail++;
            $display("FAIL frame_start_count: got %0d pulses in 70 cycles, want 3", pos.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (pos[i] != 1 + 32 * i) begin
                    n_fail++;
                    $display("FAIL frame_start_pos%0d: got sample %0d, want %0d",
                             i, pos[i], 1 + 32 * i);
                end
            end
        end
    endtask

    task automatic test_basic_scan;
        logic [3:0] a; logic [7:0] s; int len, gap; bit to;
        exp_t e;
        wait_frame(to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL basic_frame_wait: got timeout, want frame_start"); end
        push4(8'h99, 8'hB0, 8'hA4, 8'hF9);
        for (int i = 0; i < 4; i++) begin
            capture(a, s, len, gap, to);
            e = sb.pop_front();
            n_checks++;
            if (to || {a, s} !== {e.a, e.s} || len != 6) begin
                n_fail++;
                $display("FAIL basic_digit%0d: got anode=%b seg=%h len=%0d to=%0b, want %b %h len=6",
                         i, a, s, len, to, e.a, e.s);
            end
            if (i > 0) begin
                n_checks++;
                if (gap != 2) begin
                    n_fail++;
                    $display("FAIL basic_gap%0d: got %0d blank cycles, want 2", i, gap);
                end
            end
        end
    endtask

    task automatic test_sel_change;
        logic [3:0] a; logic [7:0] s; int len, gap; bit to;
        exp_t e;
        src_data = set_src(src_data, 1, 16'hABCD);
        push4(8'h99, 8'hB0, 8'hA4, 8'hF9);
        for (int i = 0; i < 2; i++) begin
            capture(a, s, len, gap, to);
            e = sb.pop_front();
            n_checks++;
            if (to || {a, s} !== {e.a, e.s}) begin
                n_fail++;
                $display("FAIL sel_old_digit%0d: got anode=%b seg=%h, want %b %h", i, a, s, e.a, e.s);
            end
        end
        wait_anode(4'b1011, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL sel_wait_d2: got timeout, want anode 1011"); end
        src_sel = 2'd1;
        void'(sb.pop_front());
        capture(a, s, len, gap, to);
        e = sb.pop_front();
        n_checks++;
        if (to || {a, s} !== {e.a, e.s}) begin
            n_fail++;
            $display("FAIL sel_old_digit3: got anode=%b seg=%h, want %b %h", a, s, e.a, e.s);
        end
        push4(8'hA1, 8'hC6, 8'h83, 8'h88);
        for (int i = 0; i < 4; i++) begin
            capture(a, s, len, gap, to);
            e = sb.pop_front();
            n_checks++;
            if (to || {a, s} !== {e.a, e.s}) begin
                n_fail++;
                $display("FAIL sel_new_digit%0d: got anode=%b seg=%h, want %b %h", i, a, s, e.a, e.s);
            end
        end
    endtask

    task automatic test_hold;
        logic [3:0] a; logic [7:0] s; int len, gap; bit to;
        exp_t e;
        wait_frame(to);
        hold = 1'b1;
        src_data = set_src(src_data, 1, 16'h5678);
        for (int f = 0; f < 4; f++) begin
            if (f == 2) hold = 1'b0;
            if (f == 3) push4(8'h80, 8'hF8, 8'h82, 8'h92);
            else        push4(8'hA1, 8'hC6, 8'h83, 8'h88);
            for (int i = 0; i < 4; i++) begin
                capture(a, s, len, gap, to);
                e = sb.pop_front();
                n_checks++;
                if (to || {a, s} !== {e.a, e.s}) begin
                    n_fail++;
                    $display("FAIL hold_f%0d_digit%0d: got anode=%b seg=%h, want %b %h",
                             f, i, a, s, e.a, e.s);
                end
            end
            if (f < 3) begin
                wait_frame(to);
                n_checks++;
                if (to) begin n_fail++; $display("FAIL hold_fs%0d: got timeout, want frame_start", f); end
            end
        end
    endtask

    task automatic test_lzb_dp;
        logic [3:0] a; logic [7:0] s; int len, gap; bit to;
        exp_t e;
        src_sel  = 2'd0;
        src_data = set_src(src_data, 0, 16'h0070);
        dp_in    = 4'b0100;
        for (int i = 0; i < 4; i++) capture(a, s, len, gap, to);
`ifdef SEG7_LZB_EN
        push4(8'hC0, 8'hF8, 8'h7F, 8'hFF);
`else
        push4(8'hC0, 8'hF8, 8'h40, 8'hC0);
`endif
        for (int i = 0; i < 4; i++) begin
            capture(a, s, len, gap, to);
            e = sb.pop_front();
            n_checks++;
            if (to || {a, s} !== {e.a, e.s}) begin
                n_fail++;
                $display("FAIL lzb_digit%0d: got anode=%b seg=%h, want %b %h", i, a, s, e.a, e.s);
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        logic [3:0] a; logic [7:0] s; int len, gap; bit to;
        exp_t e;
        wait_anode(4'b0111, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL rst_wait_d3: got timeout, want anode 0111"); end
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({anode, segment, frame_start} !== {4'hF, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_async_blank: got anode=%b seg=%h fs=%b, want 1111 ff 0",
                     anode, segment, frame_start);
        end
        src_data = set_src(src_data, 0, 16'h4C2E);
        dp_in    = '0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({anode, frame_start} !== {4'hF, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_restart_fs: got anode=%b fs=%b, want 1111 1", anode, frame_start);
        end
        push4(8'h86, 8'hA4, 8'hC6, 8'h99);
        for (int i = 0; i < 4; i++) begin
            capture(a, s, len, gap, to);
            e = sb.pop_front();
            n_checks++;
            if (to || {a, s} !== {e.a, e.s}) begin
                n_fail++;
                $display("FAIL rst_digit%0d: got anode=%b seg=%h, want %b %h", i, a, s, e.a, e.s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_sel_change();
        test_hold();
        test_lzb_dp();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
